// File: rtl/si_mem_arbiter.sv
// Shares the core's single memory port between instruction fetch and load/store, one transaction at a time.
// Load/store wins ties; instruction fetch is forced through after STARVE_MAX consecutive load/store grants it sat out.
module si_mem_arbiter #(
  parameter int MEM_AW     = 32,
  parameter int MEM_DW     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [MEM_AW-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [MEM_DW-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [MEM_AW-1:0] ls_addr_i,
  input  logic [MEM_DW-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [MEM_DW-1:0] ls_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [MEM_DW-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [MEM_DW-1:0] mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;  // 1 = load/store owns the transaction
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [MEM_DW-1:0] wdata_q, wdata_d;

  logic if_win, ls_win, accept, resp;

  assign if_win = if_req_i && (!ls_req_i || (cnt_q == STARVE_LIM));
  assign ls_win = ls_req_i && !if_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (if_win || ls_win) begin
          state_d = S_ISSUE;
          owner_d = ls_win;
          we_d    = ls_win && ls_we_i;
          addr_d  = ls_win ? ls_addr_i : if_addr_i;
          wdata_d = ls_win ? ls_wdata_i : '0;
          // Only a load/store grant that bypassed a waiting fetch counts toward starvation
          if (if_win || !if_req_i) cnt_d = '0;
          else if (cnt_q != STARVE_LIM) cnt_d = cnt_q + 4'd1;
        end
      end
      S_ISSUE: begin
        if (mem_gnt_i) state_d = mem_rvalid_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Responses are accepted only once the request has been granted by memory
  assign accept = ((state_q == S_ISSUE) && mem_gnt_i) || (state_q == S_WAIT);
  assign resp   = accept && mem_rvalid_i;

  always_comb begin
    if_gnt_o    = !rst && (state_q == S_IDLE) && if_win;
    ls_gnt_o    = !rst && (state_q == S_IDLE) && ls_win;
    mem_req_o   = (state_q == S_ISSUE);
    mem_we_o    = mem_req_o && we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if_rvalid_o = resp && !owner_q;
    ls_rvalid_o = resp && owner_q;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
    busy_o      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_si_mem_arbiter.sv
// Directed bench for si_mem_arbiter: inputs change 1ns after the rising edge, outputs are checked on the falling edge.
module tb_si_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, ls_req_i, ls_we_i;
  logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i;
  logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
  logic [31:0] if_rdata_o, ls_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  si_mem_arbiter #(.MEM_AW(32), .MEM_DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  task automatic settle; @(negedge clk); endtask
  task automatic next;   @(posedge clk); #1; endtask

  task automatic idle_inputs;
    if_req_i = 0; if_addr_i = 0; ls_req_i = 0; ls_we_i = 0; ls_addr_i = 0; ls_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic test_reset;
    settle;
    tests++; if ({if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_req_o, mem_we_o, busy_o} !== 7'b0) begin failed++; $display("FAIL reset_ctrl: got %b exp 0000000", {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_req_o, mem_we_o, busy_o}); end
    tests++; if ({mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o} !== 128'b0) begin failed++; $display("FAIL reset_data: got %h exp 0", {mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o}); end
  endtask

  task automatic test_if_fetch;
    if_req_i = 1; if_addr_i = 32'h100;
    settle;
    tests++; if ({if_gnt_o, ls_gnt_o} !== 2'b10) begin failed++; $display("FAIL fetch_gnt: got %b exp 10", {if_gnt_o, ls_gnt_o}); end
    next; if_req_i = 0;
    settle;
    tests++; if ({mem_req_o, mem_we_o, if_gnt_o} !== 3'b100 || mem_addr_o !== 32'h100) begin failed++; $display("FAIL fetch_issue: req/we/gnt %b addr %h exp 100 / 100", {mem_req_o, mem_we_o, if_gnt_o}, mem_addr_o); end
    next; mem_gnt_i = 1;
    settle;
    tests++; if ({mem_req_o, if_rvalid_o} !== 2'b10) begin failed++; $display("FAIL fetch_gnt_cycle: req/rvalid %b exp 10", {mem_req_o, if_rvalid_o}); end
    next; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    settle;
    tests++; if ({mem_req_o, if_rvalid_o, ls_rvalid_o, busy_o} !== 4'b0101 || if_rdata_o !== 32'h13) begin failed++; $display("FAIL fetch_resp: req/ifv/lsv/busy %b rdata %h exp 0101 / 13", {mem_req_o, if_rvalid_o, ls_rvalid_o, busy_o}, if_rdata_o); end
    next; mem_rvalid_i = 0; mem_rdata_i = 0;
    settle;
    tests++; if ({busy_o, if_rvalid_o} !== 2'b00) begin failed++; $display("FAIL fetch_done: busy/ifv %b exp 00", {busy_o, if_rvalid_o}); end
    next;
  endtask

  task automatic test_ls_priority;
    if_req_i = 1; if_addr_i = 32'h200;
    ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h80; ls_wdata_i = 32'hDEADBEEF;
    settle;
    tests++; if ({if_gnt_o, ls_gnt_o} !== 2'b01) begin failed++; $display("FAIL prio_gnt: if/ls %b exp 01", {if_gnt_o, ls_gnt_o}); end
    next; ls_req_i = 0; ls_we_i = 0; mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h5;
    settle;
    tests++; if ({mem_req_o, mem_we_o} !== 2'b11 || mem_wdata_o !== 32'hDEADBEEF || mem_addr_o !== 32'h80) begin failed++; $display("FAIL prio_store: req/we %b wdata %h addr %h exp 11 / deadbeef / 80", {mem_req_o, mem_we_o}, mem_wdata_o, mem_addr_o); end
    tests++; if ({ls_rvalid_o, if_rvalid_o, if_gnt_o} !== 3'b100 || if_rdata_o !== 32'h0) begin failed++; $display("FAIL prio_store_ack: lsv/ifv/ifg %b if_rdata %h exp 100 / 0", {ls_rvalid_o, if_rvalid_o, if_gnt_o}, if_rdata_o); end
    next;
    settle;
    tests++; if ({if_gnt_o, ls_gnt_o, ls_rvalid_o} !== 3'b100) begin failed++; $display("FAIL prio_if_next: ifg/lsg/lsv %b exp 100", {if_gnt_o, ls_gnt_o, ls_rvalid_o}); end
    next; if_req_i = 0;
    settle;
    tests++; if ({mem_req_o, mem_we_o, if_rvalid_o} !== 3'b101 || mem_addr_o !== 32'h200) begin failed++; $display("FAIL prio_if_issue: req/we/ifv %b addr %h exp 101 / 200", {mem_req_o, mem_we_o, if_rvalid_o}, mem_addr_o); end
    next; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic test_starvation;
    logic exp_if;
    if_req_i = 1; if_addr_i = 32'h300; ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h40;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hA5;
    for (int g = 0; g < 10; g++) begin
      exp_if = (g == 4) || (g == 9);
      settle;
      tests++; if ({if_gnt_o, ls_gnt_o} !== {exp_if, !exp_if} || busy_o !== 1'b0) begin failed++; $display("FAIL starve_gnt[%0d]: if/ls/busy %b exp %b%b0", g, {if_gnt_o, ls_gnt_o, busy_o}, exp_if, !exp_if); end
      next;
      if (g == 9) begin if_req_i = 0; ls_req_i = 0; end
      settle;
      tests++; if ({mem_req_o, if_rvalid_o, ls_rvalid_o} !== {1'b1, exp_if, !exp_if}) begin failed++; $display("FAIL starve_resp[%0d]: req/ifv/lsv %b exp 1%b%b", g, {mem_req_o, if_rvalid_o, ls_rvalid_o}, exp_if, !exp_if); end
      next;
    end
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic test_gnt_stall;
    ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h44;
    settle;
    tests++; if (ls_gnt_o !== 1'b1) begin failed++; $display("FAIL stall_gnt: got %b exp 1", ls_gnt_o); end
    next; ls_req_i = 0; if_req_i = 1; if_addr_i = 32'h600;
    for (int c = 0; c < 5; c++) begin
      mem_rvalid_i = (c == 2); mem_rdata_i = 32'h99;
      settle;
      tests++; if ({mem_req_o, if_gnt_o, ls_gnt_o, busy_o, ls_rvalid_o, if_rvalid_o} !== 6'b100100 || mem_addr_o !== 32'h44) begin failed++; $display("FAIL stall[%0d]: req/ifg/lsg/busy/lsv/ifv %b addr %h exp 100100 / 44", c, {mem_req_o, if_gnt_o, ls_gnt_o, busy_o, ls_rvalid_o, if_rvalid_o}, mem_addr_o); end
      next;
    end
    mem_rvalid_i = 0; mem_gnt_i = 1;
    settle;
    tests++; if (ls_rvalid_o !== 1'b0) begin failed++; $display("FAIL stall_accept: lsv %b exp 0", ls_rvalid_o); end
    next; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    settle;
    tests++; if ({mem_req_o, ls_rvalid_o, if_gnt_o} !== 3'b010 || ls_rdata_o !== 32'h55) begin failed++; $display("FAIL stall_resp: req/lsv/ifg %b rdata %h exp 010 / 55", {mem_req_o, ls_rvalid_o, if_gnt_o}, ls_rdata_o); end
    next; mem_rvalid_i = 0;
    settle;
    tests++; if (if_gnt_o !== 1'b1) begin failed++; $display("FAIL stall_if_after: ifg %b exp 1", if_gnt_o); end
    next; if_req_i = 0; mem_gnt_i = 1; mem_rvalid_i = 1;
    next; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic test_fast_load;
    ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h10;
    settle;
    tests++; if (ls_gnt_o !== 1'b1) begin failed++; $display("FAIL fast_gnt: got %b exp 1", ls_gnt_o); end
    next; ls_req_i = 0; mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h1234;
    settle;
    tests++; if ({ls_rvalid_o, mem_we_o, if_rvalid_o} !== 3'b100 || ls_rdata_o !== 32'h1234 || if_rdata_o !== 32'h0) begin failed++; $display("FAIL fast_resp: lsv/we/ifv %b ls_rdata %h if_rdata %h exp 100 / 1234 / 0", {ls_rvalid_o, mem_we_o, if_rvalid_o}, ls_rdata_o, if_rdata_o); end
    next; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    settle;
    tests++; if ({busy_o, mem_req_o, ls_rvalid_o} !== 3'b000) begin failed++; $display("FAIL fast_idle: busy/req/lsv %b exp 000", {busy_o, mem_req_o, ls_rvalid_o}); end
    next;
  endtask

  task automatic test_reset_abort;
    if_req_i = 1; if_addr_i = 32'h700;
    next; if_req_i = 0; mem_gnt_i = 1;
    next; mem_gnt_i = 0;
    settle;
    tests++; if ({busy_o, mem_req_o} !== 2'b10) begin failed++; $display("FAIL abort_wait: busy/req %b exp 10", {busy_o, mem_req_o}); end
    next; rst = 1; if_req_i = 1; ls_req_i = 1; ls_addr_i = 32'h900; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
    settle;
    tests++; if ({if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_req_o, mem_we_o, busy_o} !== 7'b0 || {mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o} !== 128'b0) begin failed++; $display("FAIL abort_in_reset: ctrl %b data %h exp 0 / 0", {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_req_o, mem_we_o, busy_o}, {mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o}); end
    next; rst = 0; if_req_i = 0; ls_req_i = 0; mem_rvalid_i = 1;
    settle;
    tests++; if ({if_rvalid_o, ls_rvalid_o, busy_o, mem_req_o} !== 4'b0000) begin failed++; $display("FAIL abort_late_resp: ifv/lsv/busy/req %b exp 0000", {if_rvalid_o, ls_rvalid_o, busy_o, mem_req_o}); end
    next; idle_inputs();
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish within 50000ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    next; rst = 0;
    test_if_fetch();
    test_ls_priority();
    test_starvation();
    test_gnt_stall();
    test_fast_load();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
